pw_check: RTL and testbench

- Keypad-side password verifier, the reader/consumer of the stored main password (pw) and one-shot temporary password (pw_temp) held by the password register block.
- Assembles 4 BCD digits into display, compares on '#' submit, and asserts correct while unlocked.
- Consumes a matched temporary password by pulsing pw_temp_reset.
- Enforces lockout after repeated failures.
- display and correct feed back to the password register block for password change.

---
 rtl/pw_check.sv | 196 +++++++++++++++++++
 tb/tb_pw_check.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_check.sv
// rtl/pw_check.sv - keypad password verifier with temp-password consume and fail lockout
//
// Collects BCD digits from the keypad and checks them on '#' against the main
// password and, if it is live, the one-shot temporary password. A temporary
// match is consumed with a single-cycle pw_temp_reset pulse. Repeated failures
// lock the keypad for a fixed time. An unlock relocks by itself after a stretch
// with no key activity.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   key_valid, key_code digit strobe and BCD digit (codes 10-15 ignored)
//   star, hash          '*' and '#' key strobes
//   pw, pw_temp         main and temporary passwords, 4 BCD digits, MSD in [15:12]
//   pw_temp_valid       pw_temp holds a live value
//   display             entered digits, newest in [3:0]
//   correct             high while unlocked
//   pw_temp_reset       one-cycle pulse when the temporary password is consumed
//   fail                one-cycle pulse per rejected submit
//   lockout             high while locked
//   fail_cnt            consecutive failure count (saturates at 15)
//   digit_cnt           digits entered, 0..4
module pw_check #(
    parameter int MAX_FAIL      = 3,
    parameter int LOCK_CYCLES   = 1000,
    parameter int UNLOCK_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        star,
    input  logic        hash,
    input  logic [15:0] pw,
    input  logic [15:0] pw_temp,
    input  logic        pw_temp_valid,
    output logic [15:0] display,
    output logic        correct,
    output logic        pw_temp_reset,
    output logic        fail,
    output logic        lockout,
    output logic [3:0]  fail_cnt,
    output logic [2:0]  digit_cnt
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int UW = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD   = LW'(LOCK_CYCLES);
    localparam logic [UW-1:0] UNLOCK_LOAD = UW'(UNLOCK_CYCLES);
    localparam logic [3:0]    FAIL_LIMIT  = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTRY    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKED   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    display_q, display_d;
    logic [2:0]     digit_cnt_q, digit_cnt_d;
    logic [3:0]     fail_cnt_q, fail_cnt_d;
    logic           fail_q, fail_d;
    logic           temp_rst_q, temp_rst_d;
    logic [LW-1:0]  lock_tmr_q, lock_tmr_d;
    logic [UW-1:0]  unl_tmr_q, unl_tmr_d;

    logic           digit_ok;
    logic           ev_digit;
    logic           ev_hash;
    logic [15:0]    display_shift;
    logic [2:0]     digit_cnt_inc;
    logic [3:0]     fail_cnt_inc;

    // star > hash > digit: only the winning strobe acts this cycle.
    assign digit_ok      = key_valid && (key_code <= 4'd9);
    assign ev_hash       = hash && !star;
    assign ev_digit      = digit_ok && !star && !hash;
    assign display_shift = {display_q[11:0], key_code};
    assign digit_cnt_inc = (digit_cnt_q == 3'd4) ? 3'd4 : digit_cnt_q + 3'd1;
    assign fail_cnt_inc  = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        display_d   = display_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_d      = 1'b0;
        temp_rst_d  = 1'b0;
        lock_tmr_d  = lock_tmr_q;
        unl_tmr_d   = unl_tmr_q;

        case (state_q)
            S_IDLE: begin
                if (ev_digit) begin
                    display_d   = display_shift;
                    digit_cnt_d = digit_cnt_inc;
                    state_d     = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (star) begin
                    display_d   = 16'h0;
                    digit_cnt_d = 3'd0;
                    state_d     = S_IDLE;
                end else if (ev_hash) begin
                    if (digit_cnt_q == 3'd4 &&
                        (display_q == pw || (pw_temp_valid && display_q == pw_temp))) begin
                        state_d    = S_UNLOCKED;
                        fail_cnt_d = 4'd0;
                        unl_tmr_d  = UNLOCK_LOAD;
                        // The main password wins, so the temp one is only consumed
                        // when it alone matched.
                        temp_rst_d = (display_q != pw);
                    end else begin
                        fail_d      = 1'b1;
                        fail_cnt_d  = fail_cnt_inc;
                        display_d   = 16'h0;
                        digit_cnt_d = 3'd0;
                        if (fail_cnt_inc == FAIL_LIMIT) begin
                            state_d    = S_LOCKED;
                            lock_tmr_d = LOCK_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (ev_digit) begin
                    display_d   = display_shift;
                    digit_cnt_d = digit_cnt_inc;
                end
            end

            S_UNLOCKED: begin
                // Any key activity keeps the unlock alive; star/hash are only
                // consumed downstream.
                if (star || hash || digit_ok) begin
                    unl_tmr_d = UNLOCK_LOAD;
                    if (ev_digit) begin
                        display_d   = display_shift;
                        digit_cnt_d = digit_cnt_inc;
                    end
                end else if (unl_tmr_q <= UW'(1)) begin
                    unl_tmr_d   = '0;
                    display_d   = 16'h0;
                    digit_cnt_d = 3'd0;
                    state_d     = S_IDLE;
                end else begin
                    unl_tmr_d = unl_tmr_q - UW'(1);
                end
            end

            S_LOCKED: begin
                if (lock_tmr_q <= LW'(1)) begin
                    lock_tmr_d = '0;
                    fail_cnt_d = 4'd0;
                    state_d    = S_IDLE;
                end else begin
                    lock_tmr_d = lock_tmr_q - LW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            display_q   <= 16'h0;
            digit_cnt_q <= 3'd0;
            fail_cnt_q  <= 4'd0;
            fail_q      <= 1'b0;
            temp_rst_q  <= 1'b0;
            lock_tmr_q  <= '0;
            unl_tmr_q   <= '0;
        end else begin
            state_q     <= state_d;
            display_q   <= display_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_q      <= fail_d;
            temp_rst_q  <= temp_rst_d;
            lock_tmr_q  <= lock_tmr_d;
            unl_tmr_q   <= unl_tmr_d;
        end
    end

    assign display       = display_q;
    assign digit_cnt     = digit_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign fail          = fail_q;
    assign pw_temp_reset = temp_rst_q;
    assign correct       = (state_q == S_UNLOCKED);
    assign lockout       = (state_q == S_LOCKED);

endmodule

// File: tb/tb_pw_check.sv
// tb/tb_pw_check.sv - self-checking bench for pw_check
module tb_pw_check;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        star = 1'b0;
    logic        hash = 1'b0;
    logic [15:0] pw = 16'h1234;
    logic [15:0] pw_temp = 16'h9999;
    logic        pw_temp_valid = 1'b0;
    logic [15:0] display;
    logic        correct;
    logic        pw_temp_reset;
    logic        fail;
    logic        lockout;
    logic [3:0]  fail_cnt;
    logic [2:0]  digit_cnt;

    int checks = 0;
    int errors = 0;

    pw_check #(
        .MAX_FAIL      (3),
        .LOCK_CYCLES   (8),
        .UNLOCK_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .star          (star),
        .hash          (hash),
        .pw            (pw),
        .pw_temp       (pw_temp),
        .pw_temp_valid (pw_temp_valid),
        .display       (display),
        .correct       (correct),
        .pw_temp_reset (pw_temp_reset),
        .fail          (fail),
        .lockout       (lockout),
        .fail_cnt      (fail_cnt),
        .digit_cnt     (digit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          kv;
        logic [3:0]  kc;
        bit          st;
        bit          hs;
        logic [15:0] pt;
        bit          ptv;
        logic [15:0] e_disp;
        logic [2:0]  e_cnt;
        bit          e_cor;
        bit          e_fail;
        bit          e_tr;
        bit          e_lo;
        logic [3:0]  e_fc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit kv, logic [3:0] kc, bit st, bit hs,
                                logic [15:0] pt, bit ptv, logic [15:0] e_disp,
                                logic [2:0] e_cnt, bit e_cor, bit e_fail, bit e_tr,
                                bit e_lo, logic [3:0] e_fc);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kc = kc; v.st = st; v.hs = hs; v.pt = pt; v.ptv = ptv;
        v.e_disp = e_disp; v.e_cnt = e_cnt; v.e_cor = e_cor; v.e_fail = e_fail;
        v.e_tr = e_tr; v.e_lo = e_lo; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bundle();
        return {3'b0, display, digit_cnt, correct, fail, pw_temp_reset, lockout, fail_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key_valid = 1'b0; star = 1'b0; hash = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1; key_code = c;
        step();
        key_valid = 1'b0;
    endtask

    task automatic press_hash();
        hash = 1'b1;
        step();
        hash = 1'b0;
    endtask

    task automatic three_rejects();
        for (int i = 1; i <= 3; i++) begin
            for (int d = 0; d < 4; d++) key(4'd0);
            press_hash();
            chk("lock_seq_fail", {31'b0, fail}, 32'd1);
            chk("lock_seq_fcnt", {28'b0, fail_cnt}, i);
            chk("lock_seq_lockout", {31'b0, lockout}, (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        #1;
        chk("reset_state", bundle(), 32'd0);
        step();
        reset = 1'b0;

        // A: main password accept
        vq.push_back(mk(1,1,4'd1,0,0,16'h9999,1, 16'h0001,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd2,0,0,16'h9999,1, 16'h0012,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd3,0,0,16'h9999,1, 16'h0123,3'd3,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd4,0,0,16'h9999,1, 16'h1234,3'd4,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,1, 16'h1234,3'd4,1,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,0,16'h9999,1, 16'h1234,3'd4,1,0,0,0,4'd0));
        // B: temp password accept, one-cycle pw_temp_reset
        vq.push_back(mk(1,1,4'd9,0,0,16'h9999,1, 16'h0009,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,1, 16'h0099,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,1, 16'h0999,3'd3,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,1, 16'h9999,3'd4,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,1, 16'h9999,3'd4,1,0,1,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,0,16'h9999,1, 16'h9999,3'd4,1,0,0,0,4'd0));
        // C: same digits with temp not valid -> reject
        vq.push_back(mk(1,1,4'd9,0,0,16'h9999,0, 16'h0009,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h0099,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h0999,3'd3,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h9999,3'd4,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,0, 16'h0000,3'd0,0,1,0,0,4'd1));
        vq.push_back(mk(0,0,4'd0,0,0,16'h9999,0, 16'h0000,3'd0,0,0,0,0,4'd1));
        // D: short submit rejects, then 5 digits shift the oldest out and accept
        vq.push_back(mk(1,1,4'd5,0,0,16'h9999,0, 16'h0005,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd6,0,0,16'h9999,0, 16'h0056,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,0, 16'h0000,3'd0,0,1,0,0,4'd1));
        vq.push_back(mk(0,1,4'd7,0,0,16'h9999,0, 16'h0007,3'd1,0,0,0,0,4'd1));
        vq.push_back(mk(0,1,4'd1,0,0,16'h9999,0, 16'h0071,3'd2,0,0,0,0,4'd1));
        vq.push_back(mk(0,1,4'd2,0,0,16'h9999,0, 16'h0712,3'd3,0,0,0,0,4'd1));
        vq.push_back(mk(0,1,4'd3,0,0,16'h9999,0, 16'h7123,3'd4,0,0,0,0,4'd1));
        vq.push_back(mk(0,1,4'd4,0,0,16'h9999,0, 16'h1234,3'd4,0,0,0,0,4'd1));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,0, 16'h1234,3'd4,1,0,0,0,4'd0));
        // E: star+hash+digit together clears entry; hash in IDLE does nothing; code 12 ignored
        vq.push_back(mk(1,1,4'd1,0,0,16'h9999,0, 16'h0001,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd2,0,0,16'h9999,0, 16'h0012,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd5,1,1,16'h9999,0, 16'h0000,3'd0,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,0, 16'h0000,3'd0,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd8,0,0,16'h9999,0, 16'h0008,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd12,0,0,16'h9999,0,16'h0008,3'd1,0,0,0,0,4'd0));
        // F: main and temp both match -> main wins, no pw_temp_reset
        vq.push_back(mk(1,1,4'd1,0,0,16'h1234,1, 16'h0001,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd2,0,0,16'h1234,1, 16'h0012,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd3,0,0,16'h1234,1, 16'h0123,3'd3,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd4,0,0,16'h1234,1, 16'h1234,3'd4,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h1234,1, 16'h1234,3'd4,1,0,0,0,4'd0));
        // G: pw_temp_valid sampled only in the hash cycle
        vq.push_back(mk(1,1,4'd9,0,0,16'h9999,0, 16'h0009,3'd1,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h0099,3'd2,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h0999,3'd3,0,0,0,0,4'd0));
        vq.push_back(mk(0,1,4'd9,0,0,16'h9999,0, 16'h9999,3'd4,0,0,0,0,4'd0));
        vq.push_back(mk(0,0,4'd0,0,1,16'h9999,1, 16'h9999,3'd4,1,0,1,0,4'd0));

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            key_valid     = vq[i].kv;
            key_code      = vq[i].kc;
            star          = vq[i].st;
            hash          = vq[i].hs;
            pw_temp       = vq[i].pt;
            pw_temp_valid = vq[i].ptv;
            step();
            chk($sformatf("vec%0d", i), bundle(),
                {3'b0, vq[i].e_disp, vq[i].e_cnt, vq[i].e_cor, vq[i].e_fail,
                 vq[i].e_tr, vq[i].e_lo, vq[i].e_fc});
        end
        key_valid = 1'b0; star = 1'b0; hash = 1'b0;
        pw_temp = 16'h9999; pw_temp_valid = 1'b0;

        // Lockout: three rejects, digits ignored for 8 cycles, then release
        do_reset();
        three_rejects();
        for (int k = 1; k <= 7; k++) begin
            key(4'd5);
            chk($sformatf("locked_c%0d", k), {15'b0, display, lockout, fail_cnt},
                {15'b0, 16'h0000, 1'b1, 4'd3});
        end
        step();
        chk("lock_release", {27'b0, lockout, fail_cnt}, {27'b0, 1'b0, 4'd0});

        // Asynchronous reset in the middle of LOCKED
        three_rejects();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_locked", {27'b0, lockout, fail_cnt}, 32'd0);
        step();
        reset = 1'b0;

        // Unlock timer: a digit at cycle 10 restarts the 16-cycle window
        do_reset();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        press_hash();
        chk("unl_accept", {31'b0, correct}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("unl_hold%0d", k), {31'b0, correct}, 32'd1);
        end
        key(4'd5);
        chk("unl_digit", {13'b0, display, digit_cnt, correct}, {13'b0, 16'h2345, 3'd4, 1'b1});
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("unl_after%0d", k), {31'b0, correct}, 32'd1);
        end
        step();
        chk("unl_expire", {12'b0, display, digit_cnt, correct}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
